// File: rtl/fb_pkg.sv
// Shared types and helpers for the ping-pong frame buffer.
package fb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWAP  = 2'd1,
    CLEAR = 2'd2
  } fb_state_e;

  // Address bits needed to index n words (at least one bit).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/ram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
module ram_sdp
  import fb_pkg::*;
#(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned DEPTH  = 76800,
  parameter int unsigned AW     = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_buffer_pp.sv
// Double-buffered frame store: reads from the front bank, writes to the back bank.
// Define FB_CLEAR_EN to clear the new back bank to CLEAR_VAL after every swap.
module frame_buffer_pp
  import fb_pkg::*;
#(
  parameter int unsigned       DATA_W    = 12,
  parameter int unsigned       H_PIX     = 320,
  parameter int unsigned       V_PIX     = 240,
  parameter int unsigned       ADDR_W    = 17,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              front_sel,
  output logic              busy
);

  localparam int unsigned DEPTH = H_PIX * V_PIX;
  localparam int unsigned AW    = clog2(DEPTH);

  fb_state_e state_q, state_d;
  logic front_q, front_d;
  logic pend_q, pend_d;
  logic ack_q, ack_d;
  logic busy_q, busy_d;
  logic rdv_q, rd_sel_q, rd_oor_q;
  logic wr_ok_c, rd_in_c, wr_in_c, user_we_c;
  logic clr_we_c;
  logic [AW-1:0] clr_addr_c;
  logic bank_we_c;
  logic [AW-1:0] bank_waddr_c;
  logic [DATA_W-1:0] bank_wdata_c;
  logic [DATA_W-1:0] q0, q1;

`ifdef FB_CLEAR_EN
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic wr_ready_q, wr_ready_d;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (swap_req || pend_q) state_d = SWAP;
`ifdef FB_CLEAR_EN
      SWAP:  state_d = CLEAR;
      CLEAR: if (clr_cnt_q == AW'(DEPTH - 1)) state_d = IDLE;
`else
      SWAP:  state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values; front flips on the edge that enters SWAP
  always_comb begin
    front_d = front_q ^ (state_d == SWAP);
    pend_d  = (state_q == IDLE) ? 1'b0 : (pend_q | swap_req);
    ack_d   = (state_d == SWAP);
    busy_d  = (state_d != IDLE) | pend_d;
`ifdef FB_CLEAR_EN
    wr_ready_d = (state_d != CLEAR);
    clr_cnt_d  = '0;
    if (state_q == CLEAR && state_d == CLEAR) clr_cnt_d = clr_cnt_q + AW'(1);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      front_q  <= 1'b0;
      pend_q   <= 1'b0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      rdv_q    <= 1'b0;
      rd_sel_q <= 1'b0;
      rd_oor_q <= 1'b0;
    end else begin
      front_q  <= front_d;
      pend_q   <= pend_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      rdv_q    <= rd_en;
      rd_sel_q <= front_q;
      rd_oor_q <= ~rd_in_c;
    end
  end

`ifdef FB_CLEAR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_cnt_q  <= '0;
      wr_ready_q <= 1'b1;
    end else begin
      clr_cnt_q  <= clr_cnt_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  assign wr_ok_c    = wr_ready_q;
  assign clr_we_c   = (state_q == CLEAR);
  assign clr_addr_c = clr_cnt_q;
`else
  assign wr_ok_c    = 1'b1;
  assign clr_we_c   = 1'b0;
  assign clr_addr_c = '0;
`endif

  // Back-bank write port: clear sequencer has the port while it runs
  assign wr_in_c      = (32'(wr_addr) < DEPTH);
  assign rd_in_c      = (32'(rd_addr) < DEPTH);
  assign user_we_c    = wr_en & wr_ok_c & wr_in_c;
  assign bank_we_c    = user_we_c | clr_we_c;
  assign bank_waddr_c = clr_we_c ? clr_addr_c : wr_addr[AW-1:0];
  assign bank_wdata_c = clr_we_c ? CLEAR_VAL : wr_data;

  ram_sdp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_bank0 (
    .clk     (clk),
    .we_i    (bank_we_c & front_q),
    .waddr_i (bank_waddr_c),
    .wdata_i (bank_wdata_c),
    .re_i    (rd_en & rd_in_c & ~front_q),
    .raddr_i (rd_addr[AW-1:0]),
    .rdata_o (q0)
  );

  ram_sdp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_bank1 (
    .clk     (clk),
    .we_i    (bank_we_c & ~front_q),
    .waddr_i (bank_waddr_c),
    .wdata_i (bank_wdata_c),
    .re_i    (rd_en & rd_in_c & front_q),
    .raddr_i (rd_addr[AW-1:0]),
    .rdata_o (q1)
  );

  assign rd_data   = (rdv_q & ~rd_oor_q) ? (rd_sel_q ? q1 : q0) : '0;
  assign rd_valid  = rdv_q;
  assign swap_ack  = ack_q;
  assign front_sel = front_q;
  assign busy      = busy_q;
`ifdef FB_CLEAR_EN
  assign wr_ready  = wr_ready_q;
`else
  assign wr_ready  = 1'b1;
`endif

endmodule

// File: tb/tb_frame_buffer_pp.sv
// Randomized bench for frame_buffer_pp against a bank-array reference model.
// Exercises the clear feature when FB_CLEAR_EN is defined.
module tb_frame_buffer_pp;

  localparam int unsigned DW = 12;
  localparam int unsigned HP = 4;
  localparam int unsigned VP = 2;
  localparam int unsigned AWB = 4;
  localparam int D = HP * VP;
  localparam logic [DW-1:0] CV = 12'h5A5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wr_en = 1'b0;
  logic [AWB-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic wr_ready;
  logic rd_en = 1'b0;
  logic [AWB-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic rd_valid;
  logic swap_req = 1'b0;
  logic swap_ack;
  logic front_sel;
  logic busy;

  always #5 clk = ~clk;

  frame_buffer_pp #(
    .DATA_W(DW), .H_PIX(HP), .V_PIX(VP), .ADDR_W(AWB), .CLEAR_VAL(CV)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .swap_req(swap_req), .swap_ack(swap_ack), .front_sel(front_sel), .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: bank contents (-1 = unknown), front index, mode 0=idle 1=swap 2=clear
  int bank [2][D];
  int m_front = 0, m_mode = 0, m_left = 0, m_rdd = 0;
  bit m_pend = 0, m_rdv = 0;

  task automatic step();
    bit ready;
    @(posedge clk);
    if (reset) begin
      if (m_mode == 2) for (int i = 0; i < D; i++) bank[1-m_front][i] = -1;
      m_mode = 0; m_front = 0; m_pend = 0; m_rdv = 0; m_rdd = 0;
    end else begin
      ready = (m_mode != 2);
      m_rdv = rd_en;
      m_rdd = (rd_en && int'(rd_addr) < D) ? bank[m_front][rd_addr] : 0;
      if (wr_en && ready && int'(wr_addr) < D) bank[1-m_front][wr_addr] = int'(wr_data);
      case (m_mode)
        0: if (swap_req || m_pend) begin m_mode = 1; m_front ^= 1; m_pend = 0; end
        1: begin
          if (swap_req) m_pend = 1;
`ifdef FB_CLEAR_EN
          m_mode = 2; m_left = D;
          for (int i = 0; i < D; i++) bank[1-m_front][i] = int'(CV);
`else
          m_mode = 0;
`endif
        end
        default: begin
          if (swap_req) m_pend = 1;
          m_left--;
          if (m_left == 0) m_mode = 0;
        end
      endcase
    end
    #1;
    check("front_sel", 32'(front_sel), 32'(m_front));
    check("swap_ack", 32'(swap_ack), 32'(m_mode == 1));
    check("busy", 32'(busy), 32'((m_mode != 0) || m_pend));
    check("wr_ready", 32'(wr_ready), 32'(m_mode != 2));
    check("rd_valid", 32'(rd_valid), 32'(m_rdv));
    if (m_rdd >= 0) check("rd_data", 32'(rd_data), 32'(m_rdd));
  endtask

  task automatic quiet();
    wr_en = 0; rd_en = 0; swap_req = 0;
  endtask

  task automatic do_write(input int a, input logic [DW-1:0] d);
    wr_en = 1; wr_addr = AWB'(a); wr_data = d; step(); wr_en = 0;
  endtask

  task automatic do_read(input int a);
    rd_en = 1; rd_addr = AWB'(a); step(); rd_en = 0;
  endtask

  task automatic do_swap();
    swap_req = 1; step(); swap_req = 0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 64; k++) begin
      if (m_mode == 0 && !m_pend) break;
      step();
    end
  endtask

  int cnt;

  initial begin
    for (int b = 0; b < 2; b++) for (int i = 0; i < D; i++) bank[b][i] = -1;
    quiet();
    step(); step();
    reset = 0;
    step();
    check("reset_front", 32'(front_sel), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_wr_ready", 32'(wr_ready), 32'd1);
    check("reset_rd_data", 32'(rd_data), 32'd0);

    // Populate both banks
    for (int i = 0; i < D; i++) do_write(i, DW'($urandom));
    do_swap(); wait_idle();
    for (int i = 0; i < D; i++) do_write(i, DW'($urandom));
    do_swap(); wait_idle();

    // Write then swap, read back from the new front
    do_write(5, 12'hABC);
    do_swap();
    check("swap_front", 32'(front_sel), 32'd1);
    wait_idle();
    do_read(5);
    check("read_after_swap", 32'(rd_data), 32'hABC);

    // Read on the swap edge comes from the old front
    do_write(5, 12'h123);
    rd_en = 1; rd_addr = 4'd5; swap_req = 1; step(); quiet();
    check("read_on_swap_edge", 32'(rd_data), 32'hABC);
    wait_idle();
    do_read(5);
    check("read_new_front", 32'(rd_data), 32'h123);

    // Out-of-range write and read
    wr_en = 1; wr_addr = AWB'(D); wr_data = 12'hFFF;
    rd_en = 1; rd_addr = AWB'(D + 3); step(); quiet();
    check("oor_rd_data", 32'(rd_data), 32'd0);
    check("oor_rd_valid", 32'(rd_valid), 32'd1);
    do_swap(); wait_idle();
    for (int i = 0; i < D; i++) do_read(i);

`ifdef FB_CLEAR_EN
    // Clear window, writes ignored, two merged requests yield one extra swap
    do_swap();
    cnt = 0;
    for (int k = 0; k < D; k++) begin
      swap_req = (k == 2 || k == 5);
      wr_en = 1; wr_addr = AWB'(k); wr_data = 12'h777;
      step();
      if (wr_ready == 1'b0) cnt++;
    end
    quiet();
    check("clear_cycles", 32'(cnt), 32'(D));
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (swap_ack) cnt++;
    end
    check("merged_ack_count", 32'(cnt), 32'd1);
    wait_idle();
    for (int i = 0; i < D; i++) begin
      do_read(i);
      check("cleared_word", 32'(rd_data), 32'(CV));
    end

    // Reset in the middle of a clear
    do_swap(); step(); step(); step();
`else
    // Reset while a swap request is pending
    swap_req = 1; step(); step(); quiet();
    check("pending_busy", 32'(busy), 32'd1);
`endif
    reset = 1; step(); reset = 0;
    check("rst_mid_front", 32'(front_sel), 32'd0);
    check("rst_mid_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_rd_valid", 32'(rd_valid), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      wr_en = 1'($urandom);
      wr_addr = AWB'($urandom_range(0, 15));
      wr_data = DW'($urandom);
      rd_en = 1'($urandom);
      rd_addr = AWB'($urandom_range(0, 15));
      swap_req = ($urandom_range(0, 11) == 0);
      step();
    end
    quiet();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
